bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
//
// PURPOSE
//   Multi-digit BCD down-counter driven by an internal prescaler: the decrement
//   counterpart of the single-digit BCD incrementor.
//   It is loaded with a BCD value, counts down one unit every PRESCALE clocks
//   while running, and flags completion at 0.
//   Feeds the 7-segment display multiplexer as a countdown/timer source.
//
// PARAMETERS
//   DIGITS    3  number of BCD digits (count width = 4*DIGITS)
//   PRESCALE  4  clocks per decrement step (>=1; 1 = decrement every clock)
//
// PORTS
//   clk        in   1          rising-edge clock
//   reset_n    in   1          asynchronous reset, active-low
//   load       in   1          load bcd_load into the counter (sync)
//   bcd_load   in   4*DIGITS   value to load; digit 0 = bits [3:0]
//   start      in   1          start/resume counting (sync)
//   pause      in   1          stop counting, hold count (sync)
//   bcd_count  out  4*DIGITS   current count, registered
//   running    out  1          1 while in RUN state
//   done       out  1          1-cycle pulse on the step that reaches 0
//   zero       out  1          1 when bcd_count == 0 (combinational on register)
//
// BEHAVIOUR
// - Reset (reset_n=0, async):
//   - bcd_count=0, prescaler=0, state=IDLE.
//   - running=0, done=0, zero=1.
// - States:
//   - IDLE: holding, not counting.
//   - RUN: prescaler active.
//   - DONE: count is 0, waiting for load.
// - Command priority, same cycle: load > pause > start.
// - load (any state):
//   - bcd_count <= bcd_load, with any nibble >9 saturated to 9.
//   - prescaler <= 0; state -> IDLE; done=0.
// - start:
//   - In IDLE with count != 0: -> RUN.
//   - In IDLE with count == 0: ignored.
//   - In RUN or DONE: ignored.
// - pause:
//   - In RUN: -> IDLE; prescaler value is kept, so resume continues the
//     partial interval.
//   - Otherwise: ignored.
// - RUN, prescaler:
//   - Counts 0..PRESCALE-1.
//   - At PRESCALE-1 it wraps to 0 and the count decrements on the same edge.
//   - The first decrement occurs PRESCALE clocks after the start edge.
// - Decrement is digit-serial ripple borrow within one cycle:
//   - digit 0 always receives a borrow.
//   - Digit with borrow: 0 -> 9 (propagate borrow), else d-1 (stop).
//   - 100 -> 099; 010 -> 009; 001 -> 000.
// - Reaching zero: when the decrement produces 0:
//   - done=1 for exactly that following cycle.
//   - state -> DONE; running=0; count holds at 0 (never wraps to 999).
// - DONE: exits only via load (or reset).
// - running reflects the registered state. done is registered and cleared
//   the next cycle.
// - Reset asserted mid-count: immediate return to reset values. After
//   deassertion the block is in IDLE; it does not auto-resume.
//
// CONFIGURATION
//   Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN
//   - Defined:
//     - The last value loaded (post-saturation) is held in a reload register
//       (reset value 0).
//     - On reaching 0: done pulses and the count reloads that value on the
//       same edge the zero would have been written.
//     - State stays RUN; prescaler restarts at 0. bcd_count never shows 0.
//     - A reload value of 0 behaves as undefined-macro.
//   - Undefined: behaviour as described above (stop in DONE).
//
// TESTING (DIGITS=3, PRESCALE=4 unless noted)
//   1. Reset: pulse reset_n low -> bcd_count=000, zero=1, running=0, done=0.
//   2. Load 0x103 then start -> sequence 103, 102, 101, 100, 099 (one step
//      every 4 clks); borrow across two digits is checked at 100 -> 099.
//   3. Load 0x002, start -> 001 then 000; done high exactly 1 clk; running=0;
//      count stays 000 for 20 further clks.
//   4. Load 0xAF5 -> bcd_count=995 (saturation). Start; pause after 6 clks
//      -> holds 994. Start again -> 993 two clks later (prescaler preserved).
//   5. Load and start asserted on the same cycle with 0x050 -> state IDLE,
//      count 050. Start on count 000 -> running stays 0, no done.
//   6. With BCD_COUNTDOWN_AUTO_RELOAD_EN, PRESCALE=1: load 0x002, start
//      -> 002, 001, 002, 001...; done pulses each time 001 is followed by 002.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Multi-digit BCD down-counter paced by an internal prescaler. It is loaded
//   with a BCD value. While running it steps down one unit every PRESCALE
//   clocks, and it flags completion when the count reaches zero. It is intended
//   as a countdown source for the 7-segment display multiplexer.
//
// Parameters
//   DIGITS    number of BCD digits (count width = 4*DIGITS)
//   PRESCALE  clocks per decrement step (>=1)
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous reset, active-low
//   load       in   load bcd_load (nibbles >9 saturate to 9); highest priority
//   bcd_load   in   value to load, digit 0 in bits [3:0]
//   start      in   start/resume counting from IDLE when count != 0
//   pause      in   RUN -> IDLE, prescaler phase kept
//   bcd_count  out  current count (registered)
//   running    out  1 while in RUN
//   done       out  1-cycle pulse on the step that reaches zero
//   zero       out  bcd_count == 0
//
// Configuration
//   BCD_COUNTDOWN_AUTO_RELOAD_EN: when defined, reaching zero reloads the last
//   loaded value and keeps running (a reload value of zero stops as normal).

module bcd_countdown_timer #(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] bcd_load,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] bcd_count,
  output logic                running,
  output logic                done,
  output logic                zero
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [W-1:0]    r_count, w_count_next;
  logic [PW-1:0]   r_pres, w_pres_next;
  logic            r_done, w_done_next;
  logic [W-1:0]    w_load_sat;
  logic [W-1:0]    w_dec;
  logic [W-1:0]    w_reload_val;
  logic            w_reload_en;

  // Clamp each loaded nibble into the BCD range.
  always_comb begin
    w_load_sat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_load_sat[4*i +: 4] = (bcd_load[4*i +: 4] > 4'd9) ? 4'd9 : bcd_load[4*i +: 4];
    end
  end

  // Ripple-borrow decrement: a zero digit with an incoming borrow becomes 9
  // and passes the borrow on; any other digit absorbs it.
  always_comb begin : p_dec
    logic borrow;
    borrow = 1'b1;
    w_dec  = r_count;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  logic [W-1:0] r_reload;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= w_load_sat;
    end
  end

  assign w_reload_val = r_reload;
  assign w_reload_en  = (r_reload != '0);
`else
  assign w_reload_val = '0;
  assign w_reload_en  = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_pres_next  = r_pres;
    w_done_next  = 1'b0;
    if (load) begin
      w_count_next = w_load_sat;
      w_pres_next  = '0;
      w_state_next = StIdle;
    end else if (pause) begin
      // Prescaler is left untouched so a resume finishes the partial interval.
      if (r_state == StRun) begin
        w_state_next = StIdle;
      end
    end else if (start && (r_state == StIdle)) begin
      if (r_count != '0) begin
        w_state_next = StRun;
      end
    end else if (r_state == StRun) begin
      if (r_pres == PresLast) begin
        w_pres_next = '0;
        if (w_dec == '0) begin
          w_done_next = 1'b1;
          if (w_reload_en) begin
            w_count_next = w_reload_val;
          end else begin
            w_count_next = w_dec;
            w_state_next = StDone;
          end
        end else begin
          w_count_next = w_dec;
        end
      end else begin
        w_pres_next = r_pres + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_count <= '0;
      r_pres  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_pres  <= w_pres_next;
      r_done  <= w_done_next;
    end
  end

  assign bcd_count = r_count;
  assign running   = (r_state == StRun);
  assign done      = r_done;
  assign zero      = (r_count == '0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer (DIGITS=3, PRESCALE=4): table-driven
// vectors, hand-written corner sequences and randomized stimulus, all checked
// against an integer-valued reference model.

module tb_bcd_countdown_timer;

  localparam int unsigned DIGITS   = 3;
  localparam int unsigned PRESCALE = 4;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [11:0] bcd_load;
  logic        start;
  logic        pause;
  logic [11:0] bcd_count;
  logic        running;
  logic        done;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: count kept as a plain integer.
  int m_val;
  int m_tick;
  int m_reload;
  bit m_run;
  bit m_pulse;

  typedef struct {
    logic        ld;
    logic [11:0] val;
    logic        st;
    logic        ps;
    logic [11:0] exp_cnt;
    logic        exp_run;
    logic        exp_done;
  } vec_t;

  vec_t        tbl[18];
  logic [11:0] seq2[4] = '{12'h102, 12'h101, 12'h100, 12'h099};

  bcd_countdown_timer #(
    .DIGITS  (DIGITS),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .bcd_load (bcd_load),
    .start    (start),
    .pause    (pause),
    .bcd_count(bcd_count),
    .running  (running),
    .done     (done),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd_to_int(input logic [11:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < 3; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] int_to_bcd(input int n);
    logic [11:0] r;
    r[3:0]  = 4'(n % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[11:8] = 4'((n / 100) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_tick = 0; m_reload = 0; m_run = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic l, input logic [11:0] v, input logic s,
                            input logic p);
    m_pulse = 0;
    if (l) begin
      m_val    = bcd_to_int(v);
      m_reload = m_val;
      m_tick   = 0;
      m_run    = 0;
    end else if (p) begin
      m_run = 0;
    end else if (s && !m_run) begin
      if (m_val != 0) m_run = 1;
    end else if (m_run) begin
      m_tick++;
      if (m_tick == PRESCALE) begin
        m_tick = 0;
        m_val--;
        if (m_val == 0) begin
          m_pulse = 1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
          if (m_reload != 0) m_val = m_reload;
          else m_run = 0;
`else
          m_run = 0;
`endif
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, 32'(bcd_count), 32'(int_to_bcd(m_val)));
    check({tag, "_running"}, 32'(running), 32'(m_run));
    check({tag, "_done"}, 32'(done), 32'(m_pulse));
    check({tag, "_zero"}, 32'(zero), 32'(m_val == 0));
  endtask

  task automatic cycle(input logic l, input logic [11:0] v, input logic s, input logic p,
                       input string tag);
    load = l; bcd_load = v; start = s; pause = p;
    @(posedge clk);
    model_step(l, v, s, p);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 12'h000, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Saturation, pause/resume with kept prescaler phase, load+start, start at 0.
    tbl[0]  = '{1'b1, 12'hAF5, 1'b0, 1'b0, 12'h995, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h995, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h995, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h995, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h995, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h994, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h994, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h994, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h994, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h994, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h994, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h994, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h993, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 12'h050, 1'b1, 1'b0, 12'h050, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h050, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};

    load = 0; bcd_load = '0; start = 0; pause = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(bcd_count), 32'h000);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_running", 32'(running), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Borrow across one and two digits.
    cycle(1'b1, 12'h103, 1'b0, 1'b0, "t2_load");
    cycle(1'b0, 12'h000, 1'b1, 1'b0, "t2_start");
    for (int k = 0; k < 4; k++) begin
      repeat (4) idle("t2_run");
      check("t2_step", 32'(bcd_count), 32'(seq2[k]));
    end

    // Reaching zero.
    cycle(1'b1, 12'h002, 1'b0, 1'b0, "t3_load");
    cycle(1'b0, 12'h000, 1'b1, 1'b0, "t3_start");
    repeat (4) idle("t3_run");
    check("t3_one", 32'(bcd_count), 32'h001);
    repeat (4) idle("t3_run");
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    check("t3_reload_count", 32'(bcd_count), 32'h002);
    check("t3_reload_done", 32'(done), 32'd1);
    check("t3_reload_running", 32'(running), 32'd1);
    idle("t3_after");
    check("t3_done_clear", 32'(done), 32'd0);
`else
    check("t3_zero_count", 32'(bcd_count), 32'h000);
    check("t3_zero_done", 32'(done), 32'd1);
    check("t3_zero_running", 32'(running), 32'd0);
    idle("t3_after");
    check("t3_done_clear", 32'(done), 32'd0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 12'h000, 1'b1, 1'b0, "t3_hold");
      check("t3_hold_count", 32'(bcd_count), 32'h000);
      check("t3_hold_done", 32'(done), 32'd0);
    end
`endif

    // Table vectors.
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].ld, tbl[i].val, tbl[i].st, tbl[i].ps, "tbl");
      check($sformatf("tbl%0d_count", i), 32'(bcd_count), 32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_running", i), 32'(running), 32'(tbl[i].exp_run));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].exp_done));
    end

    // Asynchronous reset mid-count; no auto-resume afterwards.
    cycle(1'b1, 12'h050, 1'b0, 1'b0, "rst_load");
    cycle(1'b0, 12'h000, 1'b1, 1'b0, "rst_start");
    repeat (6) idle("rst_run");
    reset_n = 1'b0;
    #2;
    model_reset();
    check("rst_async_count", 32'(bcd_count), 32'h000);
    check("rst_async_running", 32'(running), 32'd0);
    check("rst_async_zero", 32'(zero), 32'd1);
    check("rst_async_done", 32'(done), 32'd0);
    #1 reset_n = 1'b1;
    repeat (5) idle("rst_after");
    check("rst_no_resume", 32'(running), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic        l, s, p;
      logic [11:0] v;
      int          sel;
      l   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 15);
      p   = ($urandom_range(0, 99) < 3);
      sel = int'($urandom_range(0, 3));
      if (sel < 2) v = 12'($urandom_range(0, 8));
      else if (sel == 2) v = 12'($urandom_range(0, 48));
      else v = 12'($urandom);
      if ($urandom_range(0, 999) < 3) begin
        reset_n = 1'b0;
        #2;
        model_reset();
        check_model("rnd_reset");
        #1 reset_n = 1'b1;
      end
      cycle(l, v, s, p, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
